// File: rtl/sha256_digest_reader_pkg.sv
// Shared SHA-256 types and constants for the hash core, accumulators and readout.
// Latency: n/a (types, constants and a pure word-select helper only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int WORDS = 8;

  typedef logic [31:0]          word_t;
  typedef logic [WORDS*32-1:0]  digest_t;

  // Initial hash values H0..H7, H0 in the top word; the accumulator bank loads these.
  localparam digest_t H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Readout FSM encoding.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Word idx of a digest, counting H0 (bits [255:224]) as word 0.
  function automatic word_t digest_word(digest_t d, logic [2:0] idx);
    return d[(WORDS - 1 - int'(idx)) * 32 +: 32];
  endfunction

endpackage

// File: rtl/sha256_digest_reader_if.sv
// Capture and word-stream signals between the hash core, the reader and its consumer.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the word stream; ready_o tells the core when a digest is taken.
interface sha256_digest_reader_if;
  import sha256_pkg::*;

  logic        digest_valid;
  digest_t     digest_in;
  logic        ready_o;
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        hit;
  logic        hit_valid;
  logic        overrun;

  modport master (
    output digest_valid, digest_in, out_ready,
    input  ready_o, out_valid, out_data, out_index, out_last, hit, hit_valid, overrun
  );

  modport slave (
    input  digest_valid, digest_in, out_ready,
    output ready_o, out_valid, out_data, out_index, out_last, hit, hit_valid, overrun
  );

endinterface

// File: rtl/sha256_digest_reader_zero_prefix.sv
// Flags a 256-bit value whose ZERO_BITS most significant bits are all zero (mining hit).
// Latency: combinational.
// Backpressure: none.
module sha256_zero_prefix #(
  parameter int ZERO_BITS = 32
) (
  input  logic [255:0] din,
  output logic         hit
);

  // Leading-bit window compared against zero; legal widths are 1..256.
  assign hit = (din[255 -: ZERO_BITS] == '0);

endmodule

// File: rtl/sha256_digest_reader.sv
// Captures a completed SHA-256 digest and streams it out as eight words, H0 first.
// Latency: digest_valid at t gives H0 (and hit/hit_valid) at t+1; one word per cycle after.
// Backpressure: out_ready stalls the stream; digests offered while ready_o=0 are dropped (overrun).
module sha256_digest_reader
  import sha256_pkg::*;
#(
  parameter int ZERO_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sha256_digest_reader_if.slave  bus
);

  logic [0:0]  state;
  digest_t     shadow;
  logic [2:0]  idx;
  logic        hit_q;
  logic        hit_valid_q;
  logic        overrun_q;
  logic        hit_nxt;
  logic        last_word;
  logic        handshake;
  logic        capture;

  assign last_word = (idx == 3'(WORDS - 1));
  assign handshake = (state == SEND) && bus.out_ready;

  // Accept a new digest when idle, or when the final word leaves this cycle (no bubble).
  assign bus.ready_o = (state == IDLE) || ((state == SEND) && last_word && bus.out_ready);
  assign capture     = bus.digest_valid && bus.ready_o;

  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = (state == SEND) ? digest_word(shadow, idx) : '0;
  assign bus.out_index = idx;
  assign bus.out_last  = (state == SEND) && last_word;
  assign bus.hit       = hit_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.overrun   = overrun_q;

  // Hit is judged on the incoming digest so it is ready alongside H0.
  sha256_zero_prefix #(.ZERO_BITS(ZERO_BITS)) u_zero_prefix (
    .din (digest_in_w()),
    .hit (hit_nxt)
  );

  function automatic digest_t digest_in_w();
    return bus.digest_in;
  endfunction

  // Frame FSM: capture into the shadow register, then walk the word index on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
    end else if (capture) begin
      state  <= SEND;
      shadow <= bus.digest_in;
      idx    <= '0;
    end else if (handshake) begin
      if (last_word) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Hit result and status pulses; hit holds until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      hit_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hit_valid_q <= capture;
      overrun_q   <= bus.digest_valid && !bus.ready_o;
      if (capture) begin
        hit_q <= hit_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Self-checking bench: directed steps plus a random phase, checked against a word-queue model.
// Latency: model expects H0 one cycle after an accepted digest_valid.
// Backpressure: out_ready is driven in patterns and randomly; drops are expected while busy.
module tb_sha256_digest_reader;
  import sha256_pkg::*;

  localparam int ZB = 32;
  localparam digest_t ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_digest_reader_if bus();

  sha256_digest_reader #(.ZERO_BITS(ZB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];   // words still owed to the consumer, head = currently presented
  bit    exp_hit = 1'b0;
  bit    exp_hv  = 1'b0;
  bit    exp_ov  = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A hit means the top ZB bits of the digest are all zero.
  function automatic bit ref_hit(digest_t d);
    return (d >> (256 - ZB)) == '0;
  endfunction

  function automatic void load(digest_t d);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[255 - 32*i -: 32]);
  endfunction

  function automatic digest_t rnd_digest();
    digest_t d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    if ($urandom_range(0, 2) == 0) d[255:224] = '0;
    return d;
  endfunction

  // One clock with the inputs currently driven; model and outputs checked after the edge.
  task automatic tick();
    bit      mready;
    bit      hs;
    bit      cap;
    bit      dv;
    digest_t d;
    #1;
    mready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
    chk("ready_o", 32'(bus.ready_o), 32'(mready));
    hs  = (exp_q.size() > 0) && bus.out_ready;
    dv  = bus.digest_valid;
    cap = dv && mready;
    d   = bus.digest_in;
    @(posedge clk);
    #1;
    if (hs) void'(exp_q.pop_front());
    if (cap) begin
      load(d);
      exp_hit = ref_hit(d);
    end
    exp_hv = cap;
    exp_ov = dv && !mready;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_data",  bus.out_data, exp_q[0]);
      chk("out_index", 32'(bus.out_index), 32'(8 - exp_q.size()));
      chk("out_last",  32'(bus.out_last), 32'(exp_q.size() == 1));
    end
    chk("hit",       32'(bus.hit),       32'(exp_hit));
    chk("hit_valid", 32'(bus.hit_valid), 32'(exp_hv));
    chk("overrun",   32'(bus.overrun),   32'(exp_ov));
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_budget", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(digest_t d);
    bus.digest_valid = 1'b1;
    bus.digest_in    = d;
    tick();
    bus.digest_valid = 1'b0;
  endtask

  initial begin
    int      c;
    digest_t da;
    digest_t db;
    bit      pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst_n            = 1'b0;
    bus.digest_valid = 1'b0;
    bus.digest_in    = '0;
    bus.out_ready    = 1'b0;
    #12;
    chk("rst_ready_o",   32'(bus.ready_o),   32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_index", 32'(bus.out_index), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_hit",       32'(bus.hit),       32'd0);
    chk("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
    chk("rst_overrun",   32'(bus.overrun),   32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "abc" digest at full rate
    bus.out_ready = 1'b1;
    send(ABC);
    drain(20);

    // "abc" digest with out_ready pattern 1,0,0,1,...
    send(ABC);
    c = 0;
    while (exp_q.size() > 0 && c < 64) begin
      bus.out_ready = pat[c % 4];
      tick();
      c++;
    end
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    bus.out_ready = 1'b1;

    // Zero-prefix boundaries
    send({32'h0000_0000, {7{32'hffff_ffff}}});
    drain(20);
    send({32'h0000_0001, 224'h0});
    drain(20);
    send({32'h8000_0000, 224'h0});
    drain(20);

    // Overrun while word 3 is presented
    da = rnd_digest();
    db = rnd_digest();
    send(da);
    tick();
    tick();
    tick();
    chk("ovr_at_word3", 32'(bus.out_index), 32'd3);
    send(db);
    drain(20);

    // Recapture coincident with the final handshake
    da = rnd_digest();
    db = rnd_digest();
    send(da);
    c = 0;
    while (exp_q.size() > 1 && c < 20) begin
      tick();
      c++;
    end
    send(db);
    chk("b2b_h0", bus.out_data, db[255:224]);
    drain(20);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.digest_valid = ($urandom_range(0, 5) == 0);
      bus.digest_in    = rnd_digest();
      tick();
    end
    bus.digest_valid = 1'b0;
    bus.out_ready    = 1'b1;
    drain(40);

    // Asynchronous reset mid-frame at word 5
    da = rnd_digest();
    da[255:224] = '0;
    send(da);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_index", 32'(bus.out_index), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_hit = 1'b0;
    exp_hv  = 1'b0;
    exp_ov  = 1'b0;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready_o",   32'(bus.ready_o),   32'd1);
    chk("arst_hit",       32'(bus.hit),       32'd0);
    chk("arst_out_index", 32'(bus.out_index), 32'd0);
    chk("arst_out_last",  32'(bus.out_last),  32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_hit",       32'(bus.hit),       32'd0);
    tick();
    send(rnd_digest());
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
